fetch_sequencer: RTL and testbench

//  Controller that sequences the yIF instruction-fetch stage of the sequential CPU.
//  - Owns the PC register and drives PCin into yIF.
//  - Issues fetch/execute strobes and selects the next PC: PCp4, branch target or jump target.
//  - Stops on a halt word, an instruction-count limit or a misaligned target.
//  - Replaces the hand-driven PCin/clk loop used in bench-level fetch tests.

---
 rtl/fetch_sequencer_pkg.sv | 27 ++
 rtl/fetch_sequencer_if.sv | 43 ++++
 rtl/fseq_next_pc.sv | 32 +++
 rtl/fetch_sequencer.sv | 125 ++++++++++++
 tb/tb_fetch_sequencer.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/fetch_sequencer_pkg.sv
// +-----------------------------------------------------------------------------+
// | fetch_sequencer_pkg                                                         |
// | Shared state encoding, default halt word and helpers for fetch_sequencer.   |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

package fetch_sequencer_pkg;

    typedef enum logic [1:0] {
        FSEQ_IDLE  = 2'd0,
        FSEQ_FETCH = 2'd1,
        FSEQ_EXEC  = 2'd2,
        FSEQ_HALT  = 2'd3
    } fseq_state_t;

    // ebreak encoding
    localparam logic [31:0] c_halt_word_default = 32'h0010_0073;
    localparam int          c_cnt_w_default     = 16;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_sequencer_if.sv
// +-----------------------------------------------------------------------------+
// | fetch_sequencer_if                                                          |
// | Control/datapath bundle between fetch_sequencer (slave) and its host.       |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

interface fetch_sequencer_if
    import fetch_sequencer_pkg::*;
#(
    parameter int CNT_W = c_cnt_w_default
);
    logic              start;
    logic [31:0]       entry;
    logic [31:0]       ins;
    logic [31:0]       PCp4;
    logic              stall;
    logic              branch_taken;
    logic [31:0]       branch_target;
    logic              jump;
    logic [31:0]       jump_target;
    logic [31:0]       PCin;
    logic              fetch_en;
    logic              exec_en;
    logic              halted;
    logic              err;
    logic [CNT_W-1:0]  icount;

    modport master (
        output start, entry, ins, PCp4, stall, branch_taken, branch_target,
               jump, jump_target,
        input  PCin, fetch_en, exec_en, halted, err, icount
    );

    modport slave (
        input  start, entry, ins, PCp4, stall, branch_taken, branch_target,
               jump, jump_target,
        output PCin, fetch_en, exec_en, halted, err, icount
    );

endinterface

`default_nettype wire

// File: rtl/fseq_next_pc.sv
// +-----------------------------------------------------------------------------+
// | fseq_next_pc                                                                |
// | Next-PC priority mux (jump > branch > PC+4) with misalignment flag.         |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

module fseq_next_pc
    import fetch_sequencer_pkg::*;
(
    input  wire logic        i_jump,
    input  wire logic [31:0] i_jump_target,
    input  wire logic        i_branch_taken,
    input  wire logic [31:0] i_branch_target,
    input  wire logic [31:0] i_pcp4,
    output logic      [31:0] o_next_pc,
    output logic             o_misaligned
);

    always_comb begin
        o_next_pc = i_pcp4;
        if (i_jump) begin
            o_next_pc = i_jump_target;
        end else if (i_branch_taken) begin
            o_next_pc = i_branch_target;
        end
        o_misaligned = is_misaligned(o_next_pc);
    end

endmodule

`default_nettype wire

// File: rtl/fetch_sequencer.sv
// +-----------------------------------------------------------------------------+
// | fetch_sequencer                                                             |
// | FSM owning the PC, fetch/exec strobes and retired-instruction counter.      |
// | Optional macro: FSEQ_ICOUNT_LIMIT_EN halts after MAX_INSTR retirements.     |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [31:0] HALT_WORD = c_halt_word_default,
    parameter int          CNT_W     = c_cnt_w_default,
    parameter int          MAX_INSTR = 11
) (
    input  wire logic         clk,
    input  wire logic         reset,
    fetch_sequencer_if.slave  bus
);

    fseq_state_t      r_state;
    logic [31:0]      r_pc;
    logic             r_fetch_en;
    logic             r_exec_en;
    logic             r_halted;
    logic             r_err;
    logic [CNT_W-1:0] r_icount;

    logic [31:0]      w_next_pc;
    logic             w_misaligned;
    logic [CNT_W-1:0] w_icount_inc;

    assign w_icount_inc = r_icount + CNT_W'(1);

`ifndef FSEQ_ICOUNT_LIMIT_EN
    localparam int c_unused_max_instr = MAX_INSTR;
`endif

    fseq_next_pc u_next_pc (
        .i_jump          (bus.jump),
        .i_jump_target   (bus.jump_target),
        .i_branch_taken  (bus.branch_taken),
        .i_branch_target (bus.branch_target),
        .i_pcp4          (bus.PCp4),
        .o_next_pc       (w_next_pc),
        .o_misaligned    (w_misaligned)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= FSEQ_IDLE;
            r_pc       <= 32'd0;
            r_fetch_en <= 1'b0;
            r_exec_en  <= 1'b0;
            r_halted   <= 1'b0;
            r_err      <= 1'b0;
            r_icount   <= '0;
        end else begin
            case (r_state)
                FSEQ_IDLE: begin
                    if (bus.start) begin
                        r_pc       <= bus.entry;
                        r_fetch_en <= 1'b1;
                        r_state    <= FSEQ_FETCH;
                    end
                end
                FSEQ_FETCH: begin
                    r_fetch_en <= 1'b0;
                    r_exec_en  <= 1'b1;
                    r_state    <= FSEQ_EXEC;
                end
                FSEQ_EXEC: begin
                    // Halt word outranks stall so a stalled ebreak still stops.
                    if (bus.ins == HALT_WORD) begin
                        r_exec_en <= 1'b0;
                        r_halted  <= 1'b1;
                        r_state   <= FSEQ_HALT;
                    end else if (!bus.stall) begin
                        r_exec_en <= 1'b0;
                        if (w_misaligned) begin
                            r_halted <= 1'b1;
                            r_err    <= 1'b1;
                            r_state  <= FSEQ_HALT;
                        end else begin
                            r_pc     <= w_next_pc;
                            r_icount <= w_icount_inc;
`ifdef FSEQ_ICOUNT_LIMIT_EN
                            if (w_icount_inc == CNT_W'(MAX_INSTR)) begin
                                r_halted <= 1'b1;
                                r_state  <= FSEQ_HALT;
                            end else begin
                                r_fetch_en <= 1'b1;
                                r_state    <= FSEQ_FETCH;
                            end
`else
                            r_fetch_en <= 1'b1;
                            r_state    <= FSEQ_FETCH;
`endif
                        end
                    end
                end
                FSEQ_HALT: begin
                    if (bus.start) begin
                        r_pc       <= bus.entry;
                        r_icount   <= '0;
                        r_err      <= 1'b0;
                        r_halted   <= 1'b0;
                        r_fetch_en <= 1'b1;
                        r_state    <= FSEQ_FETCH;
                    end
                end
            endcase
        end
    end

    assign bus.PCin     = r_pc;
    assign bus.fetch_en = r_fetch_en;
    assign bus.exec_en  = r_exec_en;
    assign bus.halted   = r_halted;
    assign bus.err      = r_err;
    assign bus.icount   = r_icount;

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
// +-----------------------------------------------------------------------------+
// | tb_fetch_sequencer                                                          |
// | Directed bench with a fetch-address scoreboard for fetch_sequencer.         |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_fetch_sequencer;

    localparam logic [31:0] c_nop  = 32'h0000_0013;
    localparam logic [31:0] c_halt = 32'h0010_0073;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int tests = 0;
    int fails = 0;

    logic [31:0] exp_q[$];
    logic [31:0] exp_pc;
    logic [15:0] exp_icount;

    fetch_sequencer_if #(.CNT_W(16)) bus ();

    fetch_sequencer #(
        .HALT_WORD (c_halt),
        .CNT_W     (16),
        .MAX_INSTR (11)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Stand-in for yIF's adder.
    assign bus.PCp4 = bus.PCin + 32'd4;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every fetch strobe must present the next address queued by the stimulus.
    always @(negedge clk) begin
        if (!reset && bus.fetch_en) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $error("FAIL fetch_unexpected: observed %h expected none", bus.PCin);
            end else begin
                check("fetch_pc", bus.PCin, exp_q.pop_front());
            end
        end
    end

    task automatic start_at(input logic [31:0] e);
        bus.entry  = e;
        bus.start  = 1'b1;
        exp_q.push_back(e);
        exp_pc     = e;
        exp_icount = 16'd0;
        tick();
        bus.start = 1'b0;
        check("start_fetch_en", 32'(bus.fetch_en), 32'd1);
        check("start_exec_en",  32'(bus.exec_en),  32'd0);
        check("start_halted",   32'(bus.halted),   32'd0);
        check("start_err",      32'(bus.err),      32'd0);
        check("start_icount",   32'(bus.icount),   32'd0);
        tick();
    endtask

    task automatic run_instr(input logic jmp, input logic [31:0] jt,
                             input logic br, input logic [31:0] bt);
        logic [31:0] nxt;
        check("exec_en", 32'(bus.exec_en), 32'd1);
        bus.jump          = jmp;
        bus.jump_target   = jt;
        bus.branch_taken  = br;
        bus.branch_target = bt;
        nxt = jmp ? jt : (br ? bt : exp_pc + 32'd4);
        exp_q.push_back(nxt);
        exp_pc     = nxt;
        exp_icount = exp_icount + 16'd1;
        tick();
        check("retire_fetch_en", 32'(bus.fetch_en), 32'd1);
        check("retire_exec_en",  32'(bus.exec_en),  32'd0);
        check("retire_icount",   32'(bus.icount),   32'(exp_icount));
        bus.jump         = 1'b0;
        bus.branch_taken = 1'b0;
        tick();
    endtask

    initial begin
        bus.start = 1'b0;          bus.entry = 32'd0;
        bus.ins = c_nop;           bus.stall = 1'b0;
        bus.branch_taken = 1'b0;   bus.branch_target = 32'd0;
        bus.jump = 1'b0;           bus.jump_target = 32'd0;
        exp_pc = 32'd0;            exp_icount = 16'd0;

        tick();
        tick();
        check("rst_pc",       bus.PCin,            32'd0);
        check("rst_fetch_en", 32'(bus.fetch_en),   32'd0);
        check("rst_exec_en",  32'(bus.exec_en),    32'd0);
        check("rst_halted",   32'(bus.halted),     32'd0);
        check("rst_err",      32'(bus.err),        32'd0);
        check("rst_icount",   32'(bus.icount),     32'd0);
        reset = 1'b0;
        tick();
        check("idle_fetch_en", 32'(bus.fetch_en), 32'd0);

        // Sequential NOP stream.
        start_at(32'h28);
        repeat (3) run_instr(1'b0, 32'd0, 1'b0, 32'd0);

        // Jump beats branch, then branch alone.
        run_instr(1'b1, 32'h100, 1'b1, 32'h80);
        run_instr(1'b0, 32'h100, 1'b1, 32'h80);

        // Stall with wiggling branch/jump and start inputs.
        bus.stall = 1'b1;
        bus.start = 1'b1;
        bus.entry = 32'h300;
        for (int i = 0; i < 3; i++) begin
            bus.branch_taken  = 1'b1;
            bus.branch_target = 32'h200 + 32'(i);
            bus.jump          = i[0];
            bus.jump_target   = 32'h400 + 32'(i);
            tick();
            check("stall_exec_en",  32'(bus.exec_en),  32'd1);
            check("stall_fetch_en", 32'(bus.fetch_en), 32'd0);
            check("stall_pc",       bus.PCin,          32'h80);
            check("stall_icount",   32'(bus.icount),   32'(exp_icount));
        end
        bus.stall = 1'b0;
        bus.start = 1'b0;
        run_instr(1'b0, 32'd0, 1'b1, 32'h90);

        // Misaligned branch target.
        bus.branch_taken  = 1'b1;
        bus.branch_target = 32'h82;
        tick();
        bus.branch_taken = 1'b0;
        check("mis_halted",  32'(bus.halted),  32'd1);
        check("mis_err",     32'(bus.err),     32'd1);
        check("mis_pc",      bus.PCin,         32'h90);
        check("mis_exec_en", 32'(bus.exec_en), 32'd0);
        check("mis_icount",  32'(bus.icount),  32'(exp_icount));
        tick();
        check("mis_hold_halted", 32'(bus.halted), 32'd1);
        check("mis_hold_pc",     bus.PCin,        32'h90);

        // Halt word at 0x30 (stall asserted too), then restart.
        start_at(32'h28);
        repeat (2) run_instr(1'b0, 32'd0, 1'b0, 32'd0);
        bus.ins   = c_halt;
        bus.stall = 1'b1;
        tick();
        check("hw_halted",  32'(bus.halted),  32'd1);
        check("hw_err",     32'(bus.err),     32'd0);
        check("hw_pc",      bus.PCin,         32'h30);
        check("hw_icount",  32'(bus.icount),  32'd2);
        check("hw_exec_en", 32'(bus.exec_en), 32'd0);
        bus.ins   = c_nop;
        bus.stall = 1'b0;
        tick();
        check("hw_hold_pc", bus.PCin, 32'h30);
        start_at(32'h40);
        run_instr(1'b0, 32'd0, 1'b0, 32'd0);

        // Asynchronous reset in the middle of EXEC.
        #2 reset = 1'b1;
        #1;
        check("arst_pc",       bus.PCin,          32'd0);
        check("arst_fetch_en", 32'(bus.fetch_en), 32'd0);
        check("arst_exec_en",  32'(bus.exec_en),  32'd0);
        check("arst_halted",   32'(bus.halted),   32'd0);
        check("arst_err",      32'(bus.err),      32'd0);
        check("arst_icount",   32'(bus.icount),   32'd0);
        tick();
        reset = 1'b0;
        tick();

        // Instruction-count limit.
        start_at(32'h28);
`ifdef FSEQ_ICOUNT_LIMIT_EN
        repeat (10) run_instr(1'b0, 32'd0, 1'b0, 32'd0);
        check("lim_exec_en", 32'(bus.exec_en), 32'd1);
        tick();
        check("lim_halted",   32'(bus.halted),   32'd1);
        check("lim_err",      32'(bus.err),      32'd0);
        check("lim_icount",   32'(bus.icount),   32'd11);
        check("lim_pc",       bus.PCin,          32'h54);
        check("lim_fetch_en", 32'(bus.fetch_en), 32'd0);
`else
        repeat (12) run_instr(1'b0, 32'd0, 1'b0, 32'd0);
        check("nolim_halted", 32'(bus.halted), 32'd0);
        check("nolim_icount", 32'(bus.icount), 32'd12);
        check("nolim_pc",     bus.PCin,        32'h58);
`endif

        check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
